// File: rtl/iecdrv_head_pos.sv
// rtl/iecdrv_head_pos.sv - stepper head positioner, settle timer and dirty-track save queue
// Decodes VIA stepper phases into a half-track position and queues track-save requests.
module iecdrv_head_pos #(
   parameter int MAX_HTRACK   = 80,
   parameter int START_HTRACK = 36,
   parameter int SIDES        = 1,
   parameter int SETTLE_CYC   = 16,
   parameter int QDEPTH       = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ce,
   input  logic [1:0] stp,
   input  logic       mtr,
   input  logic       side,
   input  logic       act,
   input  logic       we,
   input  logic       img_mounted,
   output logic [5:0] track,
   output logic [6:0] half_track,
   output logic       head,
   output logic       tr00_n,
   output logic       settled,
   output logic       save_req,
   output logic [5:0] save_track,
   output logic       save_head,
   input  logic       save_ack,
   output logic       q_overflow
);

   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam logic [6:0] START_HT = 7'(START_HTRACK);
   localparam logic [6:0] MAX_HT   = 7'(MAX_HTRACK);
   localparam logic [2:0] QD       = 3'(QDEPTH);

   logic [6:0]    half_q, half_d;
   logic [5:0]    track_q, track_d;
   logic          tr00_n_q, tr00_n_d;
   logic          head_q, head_d;
   logic [SW-1:0] settle_q, settle_d;
   logic          settled_q, settled_d;
   logic [1:0]    stp_old_q, stp_old_d;
   logic          stp_vld_q, stp_vld_d;
   logic          act_q, act_d;
   logic          dirty_q, dirty_d;
   logic          ovf_q, ovf_d;
   logic [1:0]    rd_q, rd_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [6:0]    mem_q [4];
   logic [6:0]    mem_d [4];
   logic          save_req_q, save_req_d;
   logic [5:0]    save_track_q, save_track_d;
   logic          save_head_q, save_head_d;

   logic [1:0] move;
   logic       step_up, step_dn, head_chg, motion, act_fall, trig;
   logic       pop, dup, push, push_ok;
   logic [6:0] entry;
   logic [2:0] wr_sum;
   logic [1:0] wr_idx, tail_idx;

   // Entries live in a 4-slot array; only the first QDEPTH slots are ever used.
   function automatic logic [1:0] wrap(input logic [2:0] v);
      logic [2:0] t;
      t = (v >= QD) ? v - QD : v;
      return 2'(t);
   endfunction

   always_comb begin
      half_d       = half_q;
      stp_old_d    = stp;
      stp_vld_d    = 1'b1;
      settle_d     = settle_q;
      act_d        = act;
      dirty_d      = dirty_q;
      ovf_d        = ovf_q;
      rd_d         = rd_q;
      cnt_d        = cnt_q;
      mem_d        = mem_q;
      track_d      = half_q[6:1];
      tr00_n_d     = |half_q[6:1];

      move    = stp - stp_old_q;
      step_up = stp_vld_q && mtr && (move == 2'd1) && (half_q != MAX_HT);
      step_dn = stp_vld_q && mtr && (move == 2'd3) && (half_q != 7'd0);
      if (step_up)
         half_d = half_q + 7'd1;
      else if (step_dn)
         half_d = half_q - 7'd1;

      head_d   = (SIDES == 2) ? side : 1'b0;
      head_chg = head_d != head_q;
      motion   = step_up || step_dn || head_chg;

      if (motion)
         settle_d = SW'(SETTLE_CYC);
      else if (ce && settle_q != '0)
         settle_d = settle_q - 1'b1;
      settled_d = settle_d == '0;

      // Saves always capture the pre-move position, so the write lands on the track it hit.
      act_fall = act_q && !act;
      trig     = dirty_q && (motion || act_fall);
      entry    = {half_q[6:1], head_q};
      wr_sum   = {1'b0, rd_q} + cnt_q;
      wr_idx   = wrap(wr_sum);
      tail_idx = wrap(wr_sum - 3'd1);
      pop      = save_ack && (cnt_q != 3'd0);
      dup      = (cnt_q > {2'b00, pop}) && (mem_q[tail_idx] == entry);
      push     = trig && !dup;
      push_ok  = push && ((cnt_q != QD) || pop);

      if (img_mounted) begin
         cnt_d   = 3'd0;
         rd_d    = 2'd0;
         dirty_d = 1'b0;
      end else begin
         if (push && !push_ok)
            ovf_d = 1'b1;
         if (push_ok)
            mem_d[wr_idx] = entry;
         cnt_d = cnt_q + {2'b00, push_ok} - {2'b00, pop};
         if (pop)
            rd_d = wrap({1'b0, rd_q} + 3'd1);
         if (trig)
            dirty_d = 1'b0;
         else if (we)
            dirty_d = 1'b1;
      end

      save_req_d   = cnt_d != 3'd0;
      save_track_d = mem_d[rd_d][6:1];
      save_head_d  = mem_d[rd_d][0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         half_q       <= START_HT;
         track_q      <= START_HT[6:1];
         tr00_n_q     <= |START_HT[6:1];
         head_q       <= 1'b0;
         settle_q     <= '0;
         settled_q    <= 1'b1;
         stp_old_q    <= 2'd0;
         stp_vld_q    <= 1'b0;
         act_q        <= 1'b0;
         dirty_q      <= 1'b0;
         ovf_q        <= 1'b0;
         rd_q         <= 2'd0;
         cnt_q        <= 3'd0;
         for (int i = 0; i < 4; i++)
            mem_q[i] <= 7'd0;
         save_req_q   <= 1'b0;
         save_track_q <= 6'd0;
         save_head_q  <= 1'b0;
      end else begin
         half_q       <= half_d;
         track_q      <= track_d;
         tr00_n_q     <= tr00_n_d;
         head_q       <= head_d;
         settle_q     <= settle_d;
         settled_q    <= settled_d;
         stp_old_q    <= stp_old_d;
         stp_vld_q    <= stp_vld_d;
         act_q        <= act_d;
         dirty_q      <= dirty_d;
         ovf_q        <= ovf_d;
         rd_q         <= rd_d;
         cnt_q        <= cnt_d;
         mem_q        <= mem_d;
         save_req_q   <= save_req_d;
         save_track_q <= save_track_d;
         save_head_q  <= save_head_d;
      end
   end

   assign half_track = half_q;
   assign track      = track_q;
   assign tr00_n     = tr00_n_q;
   assign head       = head_q;
   assign settled    = settled_q;
   assign save_req   = save_req_q;
   assign save_track = save_track_q;
   assign save_head  = save_head_q;
   assign q_overflow = ovf_q;

endmodule

// File: tb/tb_iecdrv_head_pos.sv
// tb/tb_iecdrv_head_pos.sv - directed bench for iecdrv_head_pos (double-sided build)
module tb_iecdrv_head_pos;

   logic       clk = 1'b0;
   logic       reset_n, ce, mtr, side, act, we, img_mounted, save_ack;
   logic [1:0] stp;
   logic [5:0] track, save_track;
   logic [6:0] half_track;
   logic       head, tr00_n, settled, save_req, save_head, q_overflow;
   int         checks = 0;
   int         errors = 0;

   iecdrv_head_pos #(.MAX_HTRACK(80), .START_HTRACK(36), .SIDES(2), .SETTLE_CYC(16), .QDEPTH(2)) dut (
      .clk(clk), .reset_n(reset_n), .ce(ce), .stp(stp), .mtr(mtr), .side(side), .act(act),
      .we(we), .img_mounted(img_mounted), .track(track), .half_track(half_track), .head(head),
      .tr00_n(tr00_n), .settled(settled), .save_req(save_req), .save_track(save_track),
      .save_head(save_head), .save_ack(save_ack), .q_overflow(q_overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic act_pulse();
      act = 1'b1; tick();
      act = 1'b0; tick();
   endtask

   task automatic we_pulse();
      we = 1'b1; tick();
      we = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; ce = 1'b1; mtr = 1'b0; side = 1'b0; act = 1'b0; we = 1'b0;
      img_mounted = 1'b0; save_ack = 1'b0; stp = 2'd0;
      #12;
      chk("rst_half", 32'(half_track), 36);
      chk("rst_track", 32'(track), 18);
      chk("rst_head", 32'(head), 0);
      chk("rst_tr00", 32'(tr00_n), 1);
      chk("rst_settled", 32'(settled), 1);
      chk("rst_req", 32'(save_req), 0);
      chk("rst_ovf", 32'(q_overflow), 0);
      reset_n = 1'b1;
      tick();

      // T1: step in four half-tracks
      mtr = 1'b1;
      stp = 2'd1; tick();
      chk("t1_half37", 32'(half_track), 37);
      chk("t1_settled_drop", 32'(settled), 0);
      stp = 2'd2; tick();
      stp = 2'd3; tick();
      chk("t1_half39", 32'(half_track), 39);
      chk("t1_track_lag", 32'(track), 19);
      stp = 2'd0; tick();
      chk("t1_half40", 32'(half_track), 40);
      tick();
      chk("t1_track20", 32'(track), 20);
      ce = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      ce = 1'b1;
      for (int i = 0; i < 14; i++) tick();
      chk("t1_settle_hold", 32'(settled), 0);
      tick();
      chk("t1_settle_done", 32'(settled), 1);

      // T3: back to track 18, write, then step
      stp = 2'd3; tick();
      stp = 2'd2; tick();
      stp = 2'd1; tick();
      stp = 2'd0; tick();
      tick();
      chk("t3_track18", 32'(track), 18);
      we_pulse();
      stp = 2'd1; tick();
      chk("t3_half37", 32'(half_track), 37);
      chk("t3_req", 32'(save_req), 1);
      chk("t3_strack", 32'(save_track), 18);
      chk("t3_shead", 32'(save_head), 0);
      stp = 2'd2; tick();
      save_ack = 1'b1; tick();
      save_ack = 1'b0;
      chk("t3_single", 32'(save_req), 0);

      // T5: no motion with motor off or a double-phase jump
      mtr = 1'b0;
      stp = 2'd3; tick();
      stp = 2'd0; tick();
      chk("t5_mtr_off", 32'(half_track), 38);
      mtr = 1'b1;
      stp = 2'd2; tick();
      chk("t5_move2", 32'(half_track), 38);

      // T2: run down to 0 and hit the stop
      for (int i = 0; i < 38; i++) begin
         stp = stp - 2'd1; tick();
      end
      chk("t2_at0", 32'(half_track), 0);
      for (int i = 0; i < 17; i++) tick();
      we_pulse();
      for (int i = 0; i < 4; i++) begin
         stp = stp - 2'd1; tick();
      end
      chk("t2_clamp", 32'(half_track), 0);
      chk("t2_tr00", 32'(tr00_n), 0);
      chk("t2_settled", 32'(settled), 1);
      chk("t2_noreq", 32'(save_req), 0);
      stp = stp + 2'd1; tick();
      chk("t2_up_half", 32'(half_track), 1);
      chk("t2_up_req", 32'(save_req), 1);
      chk("t2_up_settled", 32'(settled), 0);
      save_ack = 1'b1; tick();
      save_ack = 1'b0;

      // T4: head change, act edge, duplicate, overflow
      we_pulse();
      side = 1'b1; tick();
      chk("t4_head", 32'(head), 1);
      chk("t4_req", 32'(save_req), 1);
      chk("t4_shead0", 32'(save_head), 0);
      stp = stp + 2'd1; tick();
      stp = stp + 2'd1; tick();
      chk("t4_half3", 32'(half_track), 3);
      we_pulse();
      act_pulse();
      chk("t4_qhead_stable", 32'(save_track), 0);
      we_pulse();
      act_pulse();
      chk("t4_dup_no_ovf", 32'(q_overflow), 0);
      stp = stp + 2'd1; tick();
      stp = stp + 2'd1; tick();
      we_pulse();
      act_pulse();
      chk("t4_ovf", 32'(q_overflow), 1);
      chk("t4_head_entry", 32'(save_head), 0);
      save_ack = 1'b1; tick();
      save_ack = 1'b0;
      chk("t4_pop_track", 32'(save_track), 1);
      chk("t4_pop_head", 32'(save_head), 1);
      we_pulse();
      act_pulse();
      chk("t4_refill", 32'(save_req), 1);

      // T6: flush on remount, then reset mid-settle
      img_mounted = 1'b1; tick();
      img_mounted = 1'b0;
      chk("t6_flush", 32'(save_req), 0);
      stp = stp + 2'd1; tick();
      chk("t6_half6", 32'(half_track), 6);
      chk("t6_clean", 32'(save_req), 0);
      chk("t6_ovf_sticky", 32'(q_overflow), 1);
      chk("t6_settling", 32'(settled), 0);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_half", 32'(half_track), 36);
      chk("t6_rst_track", 32'(track), 18);
      chk("t6_rst_head", 32'(head), 0);
      chk("t6_rst_tr00", 32'(tr00_n), 1);
      chk("t6_rst_settled", 32'(settled), 1);
      chk("t6_rst_ovf", 32'(q_overflow), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
